gsim_matvec: RTL and testbench
==============================

# gsim_matvec

Forward banded matrix-vector unit for the Gauss-Seidel solver path: consumes a 16-entry solution vector x (Q16.16) in the same stream format the solver emits and recomputes b = A·x for the fixed 16×16 seven-band system. Used on-chip as a self-check/residual source and as the stimulus generator that turns a known x into a b stream for the solver's input port. Output b matches the solver's 16-bit signed input format.

## Interface
- N, 16, vector length (fixed; frame = N words)
- XW, 32, x width, signed Q16.16
- BW, 16, b width, signed integer
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  x_in holds next x word (x0 first)
- x_in  input  XW  signed Q16.16 solution word
- busy  output  1  high whenever state != RECV; in_valid ignored while high
- out_valid  output  1  b_out valid this cycle
- b_out  output  BW  signed b word, b0 first
- sat  output  1  qualifies b_out: result was clipped

## Operation
- States: RECV, CALC. Reset: state RECV, word counter 0, x store 0, pipeline valid bits 0. Outputs out_valid=0, b_out=0, sat=0, busy=0.
- RECV: each cycle with in_valid=1 stores x_in at x[cnt], cnt++. Gaps (in_valid=0) allowed and hold cnt. On the 16th accepted word: cnt←0, state←CALC.
- CALC: cnt runs 0..17. For cnt<16, issue row i=cnt. At cnt=17, state←RECV and cnt←0.
- in_valid while in CALC: dropped, no side effect.
- Row i: acc = 20·x_i − 13·(x_{i−1}+x_{i+1}) + 6·(x_{i−2}+x_{i+2}) − (x_{i−3}+x_{i+3}). Indices outside 0..15 contribute 0.
- Widths: pair sums are 33 b; acc is 38 b signed. Multiplies are shift-add only: 20=16+4, 13=8+4+1, 6=4+2.
- Conversion: r = (acc + 2^15) >>> 16 (round half toward +∞). Saturate to [−32768, 32767]. sat=1 iff clipped.
- Output order is natural: b0..b15, one per cycle, no gaps.

## Timing
- Two-stage pipeline:
  - S1 registers the seven taps as pair sums plus the centre term.
  - S2 registers the combine, round and saturate into b_out/sat/out_valid.
- Row i issued at CALC cnt=i. b_i is visible while CALC cnt=i+2.
- out_valid is high for exactly 16 consecutive cycles, CALC cnt=2..17.
- Last accepted x at cycle T: state=CALC from T+1, b0 at T+3, b15 at T+18. RECV and busy=0 from T+19; a new frame's first word is accepted at T+19.
- Between frames, out_valid is low and b_out/sat hold their last values.
- Reset mid-frame or mid-CALC: immediate return to reset state. Partially received x is discarded and no further out_valid occurs.

## Structure
- gsim_pkg holds:
  - N, XW, BW, ACCW=38
  - coefficient constants C0=20, C1=13, C2=6, C3=1
  - frac-bit count 16
  - state enum {RECV, CALC}
- The solver and this block both import gsim_pkg.
- One sub-module, gsim_row_mac: combinational pair-sum inputs → rounded/saturated BW result plus sat flag. Instantiated once between S1 and S2.
- Top level holds the x store (16×XW), counter/FSM, tap mux with edge zeroing, and the pipeline registers.

## Test plan
- Zero frame (all x=0) → 16 outputs b=0, sat=0, out_valid contiguous 16 cycles starting 3 cycles after last x.
- All x=1.0 (0x00010000) → b = 12, −1, 5, 4×10, 5, −1, 12.
- Impulse x5=1.0, others 0 → b2..b8 = −1, 6, −13, 20, −13, 6, −1; all other b=0.
- Rounding: x5=0.5 (0x00008000), others 0 → b2=0 (−0.5), b3=3, b4=−6 (−6.5), b5=10, b6=−6, b7=3, b8=0.
- Saturation: x_i = (−1)^i·32767.0 → interior b clip to +32767/−32768 with sat=1. Edge rows are checked against the formula.
- Control: random in_valid gaps; in_valid held high during CALC (dropped, next frame intact); reset asserted mid-RECV and mid-CALC → outputs 0, busy=0, following frame correct.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared constants and types for the Gauss-Seidel seven-band datapath.
// Imported by both the solver and the forward matrix-vector unit.
package gsim_pkg;

  localparam int N    = 16;
  localparam int XW   = 32;
  localparam int BW   = 16;
  localparam int ACCW = 38;
  localparam int FRAC = 16;
  localparam int CNTW = 5;

  localparam int C0 = 20;
  localparam int C1 = 13;
  localparam int C2 = 6;
  localparam int C3 = 1;

  typedef enum logic {RECV, CALC} state_t;

endpackage

// File: rtl/gsim_row_mac.sv
// Combinational row combine for the seven-band stencil: shift-add weighting,
// round half toward +inf, and saturation to the solver's b format.
module gsim_row_mac
  import gsim_pkg::*;
#(
  parameter int DATA_W = XW
) (
  input  logic signed [DATA_W-1:0] ctr_i,
  input  logic signed [DATA_W:0]   pr1_i,
  input  logic signed [DATA_W:0]   pr2_i,
  input  logic signed [DATA_W:0]   pr3_i,
  output logic signed [BW-1:0]     b_o,
  output logic                     sat_o
);

  localparam int RW = ACCW - FRAC;
  localparam logic signed [RW-1:0] MAXV = RW'((1 <<< (BW - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(1 <<< (BW - 1)));

  function automatic logic signed [RW-1:0] round_half_up(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] t;
    t = a + ACCW'(1 <<< (FRAC - 1));
    return t[ACCW-1:FRAC];
  endfunction

  function automatic logic [BW:0] clip(input logic signed [RW-1:0] r);
    if (r > MAXV)      return {1'b1, 1'b0, {(BW-1){1'b1}}};
    else if (r < MINV) return {1'b1, 1'b1, {(BW-1){1'b0}}};
    else               return {1'b0, r[BW-1:0]};
  endfunction

  logic signed [ACCW-1:0] c_x, p1_x, p2_x, p3_x, acc;
  logic signed [RW-1:0]   rnd;

  // 20 = 16+4, 13 = 8+4+1, 6 = 4+2; the far pair carries unit weight
  always_comb begin
    c_x  = ACCW'(ctr_i);
    p1_x = ACCW'(pr1_i);
    p2_x = ACCW'(pr2_i);
    p3_x = ACCW'(pr3_i);
    acc  = (c_x <<< 4) + (c_x <<< 2)
         - ((p1_x <<< 3) + (p1_x <<< 2) + p1_x)
         + (p2_x <<< 2) + (p2_x <<< 1)
         - p3_x;
    rnd  = round_half_up(acc);
    {sat_o, b_o} = clip(rnd);
  end

endmodule

// File: rtl/gsim_matvec.sv
// Forward banded mat-vec: collects a 16-word x frame, then streams b = A*x
// through a two-stage tap/combine pipeline, one row per cycle.
module gsim_matvec
  import gsim_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [XW-1:0] x_in,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [BW-1:0] b_out,
  output logic                 sat
);

  localparam logic [CNTW-1:0] LAST_WORD = CNTW'(N - 1);
  localparam logic [CNTW-1:0] LAST_CALC = CNTW'(N + 1);

  function automatic logic signed [XW:0] pair(input logic signed [XW-1:0] a,
                                              input logic signed [XW-1:0] b);
    return (XW+1)'(a) + (XW+1)'(b);
  endfunction

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic signed [XW-1:0]  x_q [N];
  logic signed [XW-1:0]  x_d [N];
  logic signed [XW-1:0]  xp  [N+6];
  logic [CNTW-1:0]       row;
  logic                  issue;

  logic signed [XW-1:0]  ctr_p1_q, ctr_p1_d;
  logic signed [XW:0]    pr1_p1_q, pr1_p1_d;
  logic signed [XW:0]    pr2_p1_q, pr2_p1_d;
  logic signed [XW:0]    pr3_p1_q, pr3_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  logic signed [BW-1:0]  mac_b;
  logic                  mac_sat;
  logic signed [BW-1:0]  b_p2_q, b_p2_d;
  logic                  sat_p2_q, sat_p2_d;
  logic                  vld_p2_q, vld_p2_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    issue   = 1'b0;
    case (state_q)
      RECV: begin
        if (in_valid) begin
          x_d[cnt_q[3:0]] = x_in;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      CALC: begin
        issue = (cnt_q < CNTW'(N));
        if (cnt_q == LAST_CALC) begin
          cnt_d   = '0;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = RECV;
        cnt_d   = '0;
      end
    endcase
  end

  // Three zero words on each side implement the edge zeroing of out-of-range taps
  always_comb begin
    for (int k = 0; k < N + 6; k++) xp[k] = '0;
    for (int k = 0; k < N; k++) xp[k+3] = x_q[k];
    row      = {1'b0, cnt_q[3:0]};
    ctr_p1_d = xp[row + CNTW'(3)];
    pr1_p1_d = pair(xp[row + CNTW'(2)], xp[row + CNTW'(4)]);
    pr2_p1_d = pair(xp[row + CNTW'(1)], xp[row + CNTW'(5)]);
    pr3_p1_d = pair(xp[row],            xp[row + CNTW'(6)]);
    vld_p1_d = issue;
  end

  // S1 -> S2: combine, round, saturate; b_out/sat hold between frames
  gsim_row_mac #(.DATA_W(XW)) u_row_mac (
    .ctr_i (ctr_p1_q),
    .pr1_i (pr1_p1_q),
    .pr2_i (pr2_p1_q),
    .pr3_i (pr3_p1_q),
    .b_o   (mac_b),
    .sat_o (mac_sat)
  );

  always_comb begin
    vld_p2_d = vld_p1_q;
    b_p2_d   = vld_p1_q ? mac_b   : b_p2_q;
    sat_p2_d = vld_p1_q ? mac_sat : sat_p2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RECV;
      cnt_q    <= '0;
      for (int k = 0; k < N; k++) x_q[k] <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      b_p2_q   <= '0;
      sat_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      b_p2_q   <= b_p2_d;
      sat_p2_q <= sat_p2_d;
    end
  end

  // S1 tap registers: data only, qualified by vld_p1_q
  always_ff @(posedge clk) begin
    ctr_p1_q <= ctr_p1_d;
    pr1_p1_q <= pr1_p1_d;
    pr2_p1_q <= pr2_p1_d;
    pr3_p1_q <= pr3_p1_d;
  end

  assign busy      = (state_q == CALC);
  assign out_valid = vld_p2_q;
  assign b_out     = b_p2_q;
  assign sat       = sat_p2_q;

endmodule

// File: tb/tb_gsim_matvec.sv
// Bench for gsim_matvec: directed x frames, an arithmetic reference model of
// b = A*x, and literal expectations for the hand-computed frames.
module tb_gsim_matvec;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] x_in;
  logic               busy;
  logic               out_valid;
  logic signed [15:0] b_out;
  logic               sat;

  gsim_matvec dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .b_out     (b_out),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic signed [31:0] xf [16];
  int  exp_b [$];
  int  exp_s [$];
  int  got_b [16];
  int  gidx;
  int  last_b;
  int  pin_v [16];
  int  eb, es;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint xv(input int j);
    if (j < 0 || j > 15) return 0;
    return longint'(xf[j]);
  endfunction

  // b_i from the band weights with plain integer arithmetic
  task automatic push_model();
    longint acc, r;
    for (int i = 0; i < 16; i++) begin
      acc = 20 * xv(i) - 13 * (xv(i-1) + xv(i+1)) + 6 * (xv(i-2) + xv(i+2))
          - (xv(i-3) + xv(i+3));
      r = (acc + 32768) >>> 16;
      if (r > 32767) begin
        exp_b.push_back(32767);  exp_s.push_back(1); last_b = 32767;
      end else if (r < -32768) begin
        exp_b.push_back(-32768); exp_s.push_back(1); last_b = -32768;
      end else begin
        exp_b.push_back(int'(r)); exp_s.push_back(0); last_b = int'(r);
      end
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_b.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        eb = exp_b.pop_front();
        es = exp_s.pop_front();
        chk("b_out", b_out, eb);
        chk("sat", sat, es);
      end
      if (gidx < 16) got_b[gidx] = b_out;
      gidx++;
    end
  end

  task automatic send_words(input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          x_in     = 32'sh1234_5678;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      x_in     = xf[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input bit hold_high);
    gidx = 0;
    push_model();
    send_words(gaps, 16);
    in_valid = hold_high;
    x_in     = 32'sh7fff_ffff;
    for (int k = 1; k <= 19; k++) begin
      if (k == 19) in_valid = 1'b0;
      if (k <= 2 || k == 19) chk("out_valid_low", out_valid, 0);
      else                   chk("out_valid_run", out_valid, 1);
      chk("busy", busy, (k <= 18) ? 1 : 0);
      if (k == 19) chk("b_hold", b_out, last_b);
      if (k < 19) begin
        @(posedge clk); #1;
      end
    end
    chk("out_count", gidx, 16);
    chk("queue_drained", exp_b.size(), 0);
  endtask

  task automatic pin_check(input string name);
    for (int i = 0; i < 16; i++) chk(name, got_b[i], pin_v[i]);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_b_out"}, b_out, 0);
    chk({name, "_sat"}, sat, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) xf[i] = 32'sh0001_0000;
  endtask

  task automatic set_impulse();
    for (int i = 0; i < 16; i++) xf[i] = '0;
    xf[5] = 32'sh0001_0000;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    x_in     = '0;
    gidx     = 0;
    last_b   = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) xf[i] = '0;
    send_frame(1'b0, 1'b0);
    pin_v = '{default: 0};
    pin_check("zero_frame");

    set_ones();
    send_frame(1'b0, 1'b0);
    pin_v = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    pin_check("ones_frame");

    set_impulse();
    send_frame(1'b1, 1'b0);
    pin_v = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
    pin_check("impulse_frame");

    for (int i = 0; i < 16; i++) xf[i] = '0;
    xf[5] = 32'sh0000_8000;
    send_frame(1'b0, 1'b0);
    pin_v = '{0, 0, 0, 3, -6, 10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    pin_check("round_frame");

    for (int i = 0; i < 16; i++) xf[i] = (i % 2 == 0) ? 32'sh7fff_0000 : -32'sh7fff_0000;
    send_frame(1'b0, 1'b0);
    chk("sat_even_row", got_b[6], 32767);
    chk("sat_odd_row", got_b[7], -32768);

    for (int i = 0; i < 16; i++) xf[i] = $signed($urandom) >>> 6;
    send_frame(1'b1, 1'b1);

    // Reset while part of a frame has been received
    for (int i = 0; i < 16; i++) xf[i] = 32'sh0005_0000;
    send_words(1'b0, 7);
    reset = 1'b1;
    #1;
    reset_checks("recv_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    set_ones();
    send_frame(1'b1, 1'b0);
    pin_v = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    pin_check("after_recv_reset");

    // Reset while b words are streaming
    for (int i = 0; i < 16; i++) xf[i] = 32'sh0003_0000;
    gidx = 0;
    push_model();
    send_words(1'b0, 16);
    repeat (6) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    reset_checks("calc_reset");
    exp_b.delete();
    exp_s.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) chk("calc_reset_quiet", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("calc_reset_quiet_end", out_valid, 0);
    set_impulse();
    send_frame(1'b0, 1'b0);
    pin_v = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
    pin_check("after_calc_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
